// File: rtl/debug_link_master.sv
// Host-side UART debug link: sends one-byte commands and reassembles the dump returned by the debug unit.
// Optional trailing XOR checksum byte is enabled by defining DBG_LINK_CHECKSUM_EN.
module debug_link_master #(
   parameter int unsigned DUMP_BYTES     = 3,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   input  logic [7:0]              cmd_code,
   input  logic                    cmd_resp,
   output logic                    cmd_ready,
   output logic                    tx_start,
   output logic [7:0]              tx_data,
   input  logic                    tx_done,
   input  logic                    rx_done,
   input  logic [7:0]              rx_data,
   output logic [DUMP_BYTES*8-1:0] dump_data,
   output logic                    dump_valid,
   output logic                    busy,
   output logic                    timeout_err,
   output logic                    chk_err
);

   localparam int unsigned DW = DUMP_BYTES * 8;
`ifdef DBG_LINK_CHECKSUM_EN
   localparam int unsigned RX_BYTES = DUMP_BYTES + 1;
`else
   localparam int unsigned RX_BYTES = DUMP_BYTES;
`endif
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned CW = $clog2(RX_BYTES + 1);

   typedef enum logic [2:0] {
      IDLE,
      SEND,
      WAIT_TX,
      RECV,
      DONE
   } state_t;

   state_t          state;
   logic            resp_q;
   logic [DW-1:0]   shift_reg;
   logic [CW-1:0]   byte_cnt;
   logic [TW-1:0]   tmo_cnt;
   logic [TW-1:0]   tmo_inc;
   logic            tmo_hit;

   // Abort on the cycle the counter would reach its terminal value.
   assign tmo_inc = tmo_cnt + TW'(1);
   assign tmo_hit = (tmo_inc == TW'(TIMEOUT_CYCLES - 1));

`ifdef DBG_LINK_CHECKSUM_EN
   logic [7:0] chk_byte;
   logic [7:0] xor_calc;

   always_comb begin
      xor_calc = '0;
      for (int unsigned i = 0; i < DUMP_BYTES; i++) begin
         xor_calc = xor_calc ^ shift_reg[i*8 +: 8];
      end
   end
`else
   assign chk_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cmd_ready   <= 1'b1;
         busy        <= 1'b0;
         tx_start    <= 1'b0;
         tx_data     <= '0;
         resp_q      <= 1'b0;
         dump_data   <= '0;
         dump_valid  <= 1'b0;
         timeout_err <= 1'b0;
         shift_reg   <= '0;
         byte_cnt    <= '0;
         tmo_cnt     <= '0;
`ifdef DBG_LINK_CHECKSUM_EN
         chk_byte    <= '0;
         chk_err     <= 1'b0;
`endif
      end else begin
         tx_start    <= 1'b0;
         dump_valid  <= 1'b0;
         timeout_err <= 1'b0;
`ifdef DBG_LINK_CHECKSUM_EN
         chk_err     <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  tx_data   <= cmd_code;
                  resp_q    <= cmd_resp;
                  tx_start  <= 1'b1;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  tmo_cnt   <= '0;
                  state     <= SEND;
               end
            end
            SEND: begin
               state <= WAIT_TX;
            end
            WAIT_TX: begin
               if (tx_done) begin
                  tmo_cnt  <= '0;
                  byte_cnt <= '0;
                  if (resp_q) begin
                     state <= RECV;
                  end else begin
                     state     <= IDLE;
                     cmd_ready <= 1'b1;
                     busy      <= 1'b0;
                  end
               end else if (tmo_hit) begin
                  timeout_err <= 1'b1;
                  state       <= IDLE;
                  cmd_ready   <= 1'b1;
                  busy        <= 1'b0;
               end else begin
                  tmo_cnt <= tmo_inc;
               end
            end
            RECV: begin
               // A byte arriving on the terminal cycle takes priority over the abort.
               if (byte_cnt == CW'(RX_BYTES)) begin
                  state <= DONE;
               end else if (rx_done) begin
`ifdef DBG_LINK_CHECKSUM_EN
                  if (byte_cnt < CW'(DUMP_BYTES)) begin
                     shift_reg <= (shift_reg << 8) | DW'(rx_data);
                  end else begin
                     chk_byte <= rx_data;
                  end
`else
                  shift_reg <= (shift_reg << 8) | DW'(rx_data);
`endif
                  byte_cnt <= byte_cnt + CW'(1);
                  tmo_cnt  <= '0;
               end else if (tmo_hit) begin
                  timeout_err <= 1'b1;
                  state       <= IDLE;
                  cmd_ready   <= 1'b1;
                  busy        <= 1'b0;
               end else begin
                  tmo_cnt <= tmo_inc;
               end
            end
            DONE: begin
`ifdef DBG_LINK_CHECKSUM_EN
               if (xor_calc == chk_byte) begin
                  dump_data  <= shift_reg;
                  dump_valid <= 1'b1;
               end else begin
                  chk_err <= 1'b1;
               end
`else
               dump_data  <= shift_reg;
               dump_valid <= 1'b1;
`endif
               state     <= IDLE;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/debug_link_master.md
Name: debug_link_master

Overview:
- Host-side end of the UART debug protocol: issues one-byte commands to the on-chip debug unit and reassembles the multi-byte datapath dump it sends back.
- Sits between a command source (bench, second FPGA, soft controller) and a uart instance: drives the uart tx_start/w_data pair and consumes r_data/rx_done.
- Used for loopback verification of the debug unit and for board-to-board debug links.

Parameters:
- DUMP_BYTES, 3, number of response bytes per dump (3 = 24-bit bus).
- TIMEOUT_CYCLES, 65535, maximum clk cycles waited for tx_done or for the next response byte.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request; accepted when cmd_valid && cmd_ready.
- cmd_code  in  8  command byte to transmit.
- cmd_resp  in  1  1 = command expects a dump response, 0 = fire-and-forget.
- cmd_ready  out  1  high only in IDLE.
- tx_start  out  1  one-cycle pulse to uart transmitter.
- tx_data  out  8  byte to transmit; stable from tx_start until tx_done.
- tx_done  in  1  uart transmitter finished current byte (one-cycle pulse).
- rx_done  in  1  uart receiver has a byte (one-cycle pulse).
- rx_data  in  8  received byte, valid with rx_done.
- dump_data  out  DUMP_BYTES*8  assembled response, first byte received in MSBs.
- dump_valid  out  1  one-cycle pulse; dump_data is complete and new.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  one-cycle pulse on timeout abort.
- chk_err  out  1  one-cycle pulse on checksum mismatch (see Optional Feature).

Behaviour:
- Reset (async, rst=1): state IDLE; tx_start, dump_valid, timeout_err, chk_err, busy = 0; cmd_ready = 1; tx_data = 0; dump_data = 0; byte counter and timeout counter = 0.
- IDLE: cmd_ready=1. On accept, latch cmd_code into tx_data and cmd_resp internally -> SEND.
- SEND: tx_start=1 for exactly this cycle -> WAIT_TX.
- WAIT_TX: wait for tx_done. On tx_done: if cmd_resp=1 -> RECV (counters cleared), else -> IDLE. Timeout counter runs; reaching TIMEOUT_CYCLES-1 -> timeout_err pulse, -> IDLE.
- RECV: on each rx_done, shift left by 8 and insert rx_data into the LSB byte of the shift register, increment the byte counter, and clear the timeout counter. After byte DUMP_BYTES, go to DONE. The timeout counter increments on cycles without rx_done; reaching TIMEOUT_CYCLES-1 -> timeout_err pulse, -> IDLE, dump_data keeps its previous value.
- DONE: copy the shift register to dump_data, pulse dump_valid, -> IDLE. Latency from the last rx_done to dump_valid is 2 cycles.
- rx_done outside RECV (IDLE, SEND, WAIT_TX): byte discarded, no state change.
- rx_done in the same cycle the timeout terminal count is reached: the byte wins and the timeout counter is cleared.
- cmd_valid while busy: ignored; no queuing.
- tx_start and dump_valid never assert in the same cycle.
- Reset mid-operation: immediate return to reset values; a partial dump is discarded.

Optional Feature:
- Macro DBG_LINK_CHECKSUM_EN.
- Defined: the response carries one extra trailing byte, the XOR of the DUMP_BYTES data bytes. RECV expects DUMP_BYTES+1 bytes and does not shift the checksum byte into the data register.
  - Match: normal DONE.
  - Mismatch: chk_err pulse, no dump_valid, dump_data unchanged, -> IDLE.
- Undefined: exactly DUMP_BYTES response bytes; chk_err is tied 0.

Test Plan:
- Dump command: cmd_code=0x64, cmd_resp=1; model tx_done 10 cycles after tx_start, then rx bytes 0x61,0x62,0x63 -> tx_data=0x64 with a single tx_start; dump_data=0x616263; one dump_valid pulse 2 cycles after the third rx_done.
- Fire-and-forget: cmd_code=0x73, cmd_resp=0 -> one tx_start; back to IDLE one cycle after tx_done; no dump_valid; cmd_ready=1.
- Timeout: TIMEOUT_CYCLES=16, send only 0x61 and 0x62 -> timeout_err pulse 15 cycles after the last rx_done; dump_data keeps its prior value; busy=0.
- Stray and back-pressure: rx_done with 0xFF in IDLE, plus cmd_valid held high during WAIT_TX -> stray byte ignored; second command accepted only once IDLE is re-entered; the next dump is correct.
- Reset mid-RECV: assert rst after 2 of 3 bytes -> outputs return to reset values immediately; dump_data=0; the next full transaction completes normally.
- With DBG_LINK_CHECKSUM_EN: bytes 0x61,0x62,0x63,0x60 -> dump_valid, dump_data=0x616263. Same bytes with a final 0x00 -> chk_err pulse, no dump_valid.
